// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants for the RV32 write-back stage
// Purpose: write-back source encodings, load funct3 codes and ctrl_wb bit positions.
// Ports: none (package).
package wb_pkg;

  // Write-back source select, carried in ctrl_wb[2:1]
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;
  localparam logic [1:0] SRC_ILL = 2'b11;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // ctrl_wb bit positions
  localparam int CTRL_WE_BIT  = 0;
  localparam int CTRL_SRC_LSB = 1;
  localparam int CTRL_SRC_MSB = 2;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - sub-word load extraction and extension
// Purpose: picks the byte/half/word addressed by ld_off_i out of mem_data_i and
//          sign- or zero-extends it to XLEN according to the load funct3.
// Ports:
//   mem_data_i  XLEN  raw memory read data
//   ld_type_i   3     load funct3
//   ld_off_i    2     byte offset within the word
//   data_o      XLEN  aligned, extended load result
//   misalign_o  1     offset not legal for the access size
//   illegal_o   1     funct3 is not a supported load
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_data_i,
  input  logic [2:0]      ld_type_i,
  input  logic [1:0]      ld_off_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o,
  output logic            illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  // Sub-word lanes always come from the low 32 bits
  assign byte_sel = mem_data_i[{ld_off_i, 3'b000} +: 8];
  assign half_sel = mem_data_i[{ld_off_i[1], 4'b0000} +: 16];
  assign word_sel = mem_data_i[31:0];

  always_comb begin
    data_o     = mem_data_i;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (ld_type_i)
      F3_LB:  data_o = XLEN'($signed(byte_sel));
      F3_LBU: data_o = XLEN'(byte_sel);
      F3_LH: begin
        data_o     = XLEN'($signed(half_sel));
        misalign_o = ld_off_i[0];
      end
      F3_LHU: begin
        data_o     = XLEN'(half_sel);
        misalign_o = ld_off_i[0];
      end
      F3_LW: begin
        data_o     = XLEN'($signed(word_sel));
        misalign_o = (ld_off_i != 2'b00);
      end
      F3_LWU: begin
        // Zero-extending word load only exists on a 64-bit datapath
        if (XLEN == 64) begin
          data_o     = XLEN'(word_sel);
          misalign_o = (ld_off_i != 2'b00);
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage_p.sv
// rtl/wb_stage_p.sv - registered RV32 write-back stage
// Purpose: holds one MEM/WB payload under valid/ready, selects the write-back
//          source, drives the register-file write port and WB->EX forwarding,
//          counts retired instructions and flags malformed write-backs.
// Optional feature macro: WB_LOAD_EXT_EN (load alignment/extension and its errors).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid / in_ready                MEM-side handshake
//   stall, flush                       downstream hold / discard held entry
//   ctrl_wb, ld_type, ld_off           write-back control and load shape
//   pc4_wb, mem_data, alu_data, rd_wb  candidate results and destination
//   op_write, write_addr, write_data   register-file write port
//   fwd_valid, fwd_addr, fwd_data      forwarding port
//   instret                            retired-instruction counter
//   wb_err                             malformed-retire pulse
module wb_stage_p
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               stall,
  input  logic               flush,
  input  logic [2:0]         ctrl_wb,
  input  logic [2:0]         ld_type,
  input  logic [1:0]         ld_off,
  input  logic [XLEN-1:0]    pc4_wb,
  input  logic [XLEN-1:0]    mem_data,
  input  logic [XLEN-1:0]    alu_data,
  input  logic [RADDR_W-1:0] rd_wb,
  output logic               op_write,
  output logic [RADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]    write_data,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_addr,
  output logic [XLEN-1:0]    fwd_data,
  output logic [CNT_W-1:0]   instret,
  output logic               wb_err
);

  logic               v_q, v_d;
  logic [2:0]         ctrl_q;
  logic [2:0]         ld_type_q;
  logic [1:0]         ld_off_q;
  logic [XLEN-1:0]    pc4_q, mem_q, alu_q;
  logic [RADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic               accept, retire, err, we;
  logic [1:0]         src;
  logic [XLEN-1:0]    load_data;
  logic               load_err;

  assign in_ready = !v_q || !stall;
  // Flush drops both the held entry and anything offered in the same cycle
  assign accept   = in_valid && in_ready && !flush;
  assign retire   = v_q && !stall && !flush;

  assign src = ctrl_q[CTRL_SRC_MSB:CTRL_SRC_LSB];
  assign we  = ctrl_q[CTRL_WE_BIT] && (rd_q != '0);

`ifdef WB_LOAD_EXT_EN
  logic ld_misalign, ld_illegal;

  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .mem_data_i (mem_q),
    .ld_type_i  (ld_type_q),
    .ld_off_i   (ld_off_q),
    .data_o     (load_data),
    .misalign_o (ld_misalign),
    .illegal_o  (ld_illegal)
  );
  assign load_err = (src == SRC_MEM) && (ld_misalign || ld_illegal);
`else
  logic unused_ld;
  assign unused_ld = ^{ld_type_q, ld_off_q};
  assign load_data = mem_q;
  assign load_err  = 1'b0;
`endif

  assign err = (src == SRC_ILL) || load_err;

  always_comb begin
    write_data = alu_q;
    case (src)
      SRC_MEM: write_data = load_data;
      SRC_PC4: write_data = pc4_q;
      default: write_data = alu_q;
    endcase
  end

  assign write_addr = rd_q;
  assign op_write   = retire && we && !err;
  assign wb_err     = retire && err;

  assign fwd_valid  = v_q && we;
  assign fwd_addr   = rd_q;
  assign fwd_data   = write_data;
  assign instret    = instret_q;

  always_comb begin
    v_d = v_q;
    if (flush)       v_d = 1'b0;
    else if (accept) v_d = 1'b1;
    else if (retire) v_d = 1'b0;
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= 1'b0;
      ctrl_q    <= '0;
      ld_type_q <= '0;
      ld_off_q  <= '0;
      pc4_q     <= '0;
      mem_q     <= '0;
      alu_q     <= '0;
      rd_q      <= '0;
      instret_q <= '0;
    end else begin
      v_q       <= v_d;
      instret_q <= instret_d;
      if (accept) begin
        ctrl_q    <= ctrl_wb;
        ld_type_q <= ld_type;
        ld_off_q  <= ld_off;
        pc4_q     <= pc4_wb;
        mem_q     <= mem_data;
        alu_q     <= alu_data;
        rd_q      <= rd_wb;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_p.sv
// tb/tb_wb_stage_p.sv - directed self-checking bench for wb_stage_p
module tb_wb_stage_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, flush;
  logic        in_ready;
  logic [2:0]  ctrl_wb, ld_type;
  logic [1:0]  ld_off;
  logic [31:0] pc4_wb, mem_data, alu_data;
  logic [4:0]  rd_wb;
  logic        op_write, fwd_valid, wb_err;
  logic [4:0]  write_addr, fwd_addr;
  logic [31:0] write_data, fwd_data;
  logic [63:0] instret;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_ir   = 0;

  wb_stage_p #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .ctrl_wb    (ctrl_wb),
    .ld_type    (ld_type),
    .ld_off     (ld_off),
    .pc4_wb     (pc4_wb),
    .mem_data   (mem_data),
    .alu_data   (alu_data),
    .rd_wb      (rd_wb),
    .op_write   (op_write),
    .write_addr (write_addr),
    .write_data (write_data),
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .instret    (instret),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] c, input logic [2:0] lt, input logic [1:0] lo,
                        input logic [31:0] p4, input logic [31:0] md, input logic [31:0] ad,
                        input logic [4:0] rd);
    ctrl_wb  = c;
    ld_type  = lt;
    ld_off   = lo;
    pc4_wb   = p4;
    mem_data = md;
    alu_data = ad;
    rd_wb    = rd;
  endtask

  // Offer one instruction for one cycle, then sample the retire cycle
  task automatic push(input logic [2:0] c, input logic [2:0] lt, input logic [1:0] lo,
                      input logic [31:0] p4, input logic [31:0] md, input logic [31:0] ad,
                      input logic [4:0] rd);
    @(negedge clk);
    set_in(c, lt, lo, p4, md, ad, rd);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(3'b000, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    @(negedge clk); @(negedge clk); #1;
    check("rst_op_write", op_write, 0);
    check("rst_addr", write_addr, 0);
    check("rst_data", write_data, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_instret", instret, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ALU write
    push(3'b001, 3'b000, 2'b00, 32'h0, 32'h0, 32'd3, 5'd4);
    check("alu_op_write", op_write, 1);
    check("alu_addr", write_addr, 4);
    check("alu_data", write_data, 3);
    check("alu_fwd_valid", fwd_valid, 1);
    exp_ir++;
    @(negedge clk); #1;
    check("alu_instret", instret, exp_ir);
    check("alu_idle_op_write", op_write, 0);

    // Loads from 0x0000_80F0
`ifdef WB_LOAD_EXT_EN
    push(3'b011, 3'b000, 2'b00, 32'h0, 32'h0000_80F0, 32'h0, 5'd5);
    check("lb_off0", write_data, 32'hFFFF_FFF0);
    check("lb_op_write", op_write, 1);
    exp_ir++;
    push(3'b011, 3'b100, 2'b01, 32'h0, 32'h0000_80F0, 32'h0, 5'd5);
    check("lbu_off1", write_data, 32'h0000_0080);
    exp_ir++;
    push(3'b011, 3'b001, 2'b10, 32'h0, 32'h0000_80F0, 32'h0, 5'd5);
    check("lh_off2", write_data, 32'h0000_0000);
    check("lh_off2_err", wb_err, 0);
    exp_ir++;
    push(3'b011, 3'b010, 2'b01, 32'h0, 32'h1234_5678, 32'h0, 5'd5);
    check("lw_misalign_err", wb_err, 1);
    check("lw_misalign_write", op_write, 0);
    exp_ir++;
    push(3'b011, 3'b011, 2'b00, 32'h0, 32'h1234_5678, 32'h0, 5'd5);
    check("ld_illegal_err", wb_err, 1);
    exp_ir++;
`else
    push(3'b011, 3'b000, 2'b00, 32'h0, 32'h0000_80F0, 32'h0, 5'd5);
    check("mem_raw_off0", write_data, 32'h0000_80F0);
    check("mem_raw_op_write", op_write, 1);
    exp_ir++;
    push(3'b011, 3'b100, 2'b01, 32'h0, 32'h0000_80F0, 32'h0, 5'd5);
    check("mem_raw_off1", write_data, 32'h0000_80F0);
    check("mem_raw_err", wb_err, 0);
    exp_ir++;
`endif

    // PC+4 to x0: no write, no forward, still retires
    push(3'b101, 3'b000, 2'b00, 32'h104, 32'h0, 32'h0, 5'd0);
    check("pc4_x0_op_write", op_write, 0);
    check("pc4_x0_fwd_valid", fwd_valid, 0);
    check("pc4_x0_data", write_data, 32'h104);
    exp_ir++;
    @(negedge clk); #1;
    check("pc4_x0_instret", instret, exp_ir);

    // Misaligned halfword
    push(3'b011, 3'b001, 2'b01, 32'h0, 32'h0000_80F0, 32'h0, 5'd6);
`ifdef WB_LOAD_EXT_EN
    check("lh_off1_err", wb_err, 1);
    check("lh_off1_write", op_write, 0);
`else
    check("lh_off1_err", wb_err, 0);
    check("lh_off1_write", op_write, 1);
`endif
    exp_ir++;
    @(negedge clk); #1;
    check("lh_off1_instret", instret, exp_ir);
    check("lh_off1_pulse_end", wb_err, 0);

    // Stall for 3 cycles after accept
    @(negedge clk);
    set_in(3'b001, 3'b000, 2'b00, 32'h0, 32'h0, 32'h55, 5'd7);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_op_write", op_write, 0);
      check("stall_in_ready", in_ready, 0);
      check("stall_fwd_valid", fwd_valid, 1);
      check("stall_fwd_data", fwd_data, 32'h55);
      check("stall_instret", instret, exp_ir);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    check("release_op_write", op_write, 1);
    check("release_addr", write_addr, 7);
    exp_ir++;
    @(negedge clk); #1;
    check("release_single_write", op_write, 0);
    check("release_instret", instret, exp_ir);

    // Flush with a simultaneous incoming instruction
    @(negedge clk);
    set_in(3'b001, 3'b000, 2'b00, 32'h0, 32'h0, 32'd9, 5'd8);
    in_valid = 1'b1;
    @(negedge clk);
    set_in(3'b001, 3'b000, 2'b00, 32'h0, 32'h0, 32'd10, 5'd9);
    flush = 1'b1;
    #1;
    check("flush_op_write", op_write, 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_after_op_write", op_write, 0);
    check("flush_after_fwd_valid", fwd_valid, 0);
    check("flush_instret", instret, exp_ir);

    // 8 back-to-back accepts
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(3'b001, 3'b000, 2'b00, 32'h0, 32'h0, 32'h100 + i, 5'(i + 1));
      in_valid = 1'b1;
      #1;
      if (i > 0) begin
        check("b2b_op_write", op_write, 1);
        check("b2b_data", write_data, 64'(32'h100 + i - 1));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("b2b_last_op_write", op_write, 1);
    check("b2b_last_data", write_data, 32'h107);
    exp_ir += 8;
    @(negedge clk); #1;
    check("b2b_drained", op_write, 0);
    check("b2b_instret", instret, exp_ir);

    // Illegal source
    push(3'b111, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd3);
    check("ill_src_err", wb_err, 1);
    check("ill_src_write", op_write, 0);
    exp_ir++;
    @(negedge clk); #1;
    check("ill_src_instret", instret, exp_ir);

    // Asynchronous reset while stalled
    @(negedge clk);
    set_in(3'b001, 3'b000, 2'b00, 32'h0, 32'h0, 32'h77, 5'd2);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    stall = 1'b1;
    #1;
    check("pre_rst_fwd_valid", fwd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_op_write", op_write, 0);
    check("arst_addr", write_addr, 0);
    check("arst_data", write_data, 0);
    check("arst_fwd_valid", fwd_valid, 0);
    check("arst_wb_err", wb_err, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_instret", instret, 0);
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_op_write", op_write, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
